// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl : fetch sequencer for a req/gnt/rvalid instruction memory
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_ctrl #(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrc_E,
  input  logic [63:0] PCTarget_E,
  input  logic        Stall_D,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] PC_D,
  output logic [31:0] Instr_D,
  output logic        Valid_D,
  output logic        fetch_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t        state;
  logic [63:0]   pc_f;
  logic [63:0]   inflight_pc;
  logic          drop;
  logic [CW-1:0] wait_cnt;
  logic          hold_valid;
  logic [63:0]   hold_pc;
  logic [31:0]   hold_instr;

  logic grant;
  logic rsp_fire;
  logic rsp_keep;
  logic ifid_hold;
  logic unused_tgt;

  // Request is gated by reset so it drops the instant reset asserts.
  assign imem_req   = rst && (state == S_REQ) && !hold_valid && !PCSrc_E;
  assign imem_addr  = pc_f;
  assign grant      = imem_req && imem_gnt;
  assign rsp_fire   = (state == S_WAIT) && imem_rvalid;
  assign rsp_keep   = rsp_fire && !PCSrc_E && !drop;
  assign ifid_hold  = Stall_D && Valid_D;
  assign unused_tgt = ^PCTarget_E[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_REQ;
      pc_f        <= RESET_PC;
      inflight_pc <= 64'h0;
      drop        <= 1'b0;
      wait_cnt    <= '0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        S_REQ: begin
          if (grant) begin
            inflight_pc <= pc_f;
            pc_f        <= pc_f + 64'd4;
            wait_cnt    <= '0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            wait_cnt <= '0;
            state    <= S_REQ;
          end else begin
            if (wait_cnt != TIMEOUT_VAL) begin
              wait_cnt <= wait_cnt + CNT_ONE;
            end
            if ((TIMEOUT_CYCLES != 0) && (wait_cnt + CNT_ONE == TIMEOUT_VAL)) begin
              fetch_err <= 1'b1;
            end
          end
        end
        default: state <= S_REQ;
      endcase

      // A redirect overrides the PC; the outstanding read, if any, becomes stale.
      if (PCSrc_E) begin
        pc_f <= {PCTarget_E[63:2], 2'b00};
        if ((state == S_WAIT) && !imem_rvalid) begin
          drop <= 1'b1;
        end
      end else if (rsp_fire && drop) begin
        drop <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC_D       <= 64'h0;
      Instr_D    <= NOP;
      Valid_D    <= 1'b0;
      hold_valid <= 1'b0;
      hold_pc    <= 64'h0;
      hold_instr <= NOP;
    end else if (PCSrc_E) begin
      PC_D       <= 64'h0;
      Instr_D    <= NOP;
      Valid_D    <= 1'b0;
      hold_valid <= 1'b0;
    end else if (ifid_hold) begin
      if (rsp_keep) begin
        hold_valid <= 1'b1;
        hold_pc    <= inflight_pc;
        hold_instr <= imem_rdata;
      end
    end else if (hold_valid) begin
      PC_D       <= hold_pc;
      Instr_D    <= hold_instr;
      Valid_D    <= 1'b1;
      hold_valid <= 1'b0;
    end else if (rsp_keep) begin
      PC_D    <= inflight_pc;
      Instr_D <= imem_rdata;
      Valid_D <= 1'b1;
    end else begin
      PC_D    <= 64'h0;
      Instr_D <= NOP;
      Valid_D <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_ctrl : directed bench for fetch_ctrl with a small memory responder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fetch_ctrl;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        PCSrc_E = 1'b0;
  logic [63:0] PCTarget_E = 64'h0;
  logic        Stall_D = 1'b0;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [63:0] PC_D;
  logic [31:0] Instr_D;
  logic        Valid_D;
  logic        fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder state
  bit          pend = 1'b0;
  logic [63:0] paddr = 64'h0;
  int          pwait = 0;
  int          lat = 1;
  bit          withhold = 1'b0;
  bit          granted;
  bit          got_rv;
  logic [63:0] gaddr;

  fetch_ctrl #(
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrc_E    (PCSrc_E),
    .PCTarget_E (PCTarget_E),
    .Stall_D    (Stall_D),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .PC_D       (PC_D),
    .Instr_D    (Instr_D),
    .Valid_D    (Valid_D),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [63:0] a);
    logic [15:0] idx;
    idx = a[17:2] - 16'h03FF;
    return {16'hAAAA, idx};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: entered at a negedge with inputs set, returns at the next negedge.
  task automatic cycle();
    #1;
    granted = imem_req && imem_gnt;
    gaddr   = imem_addr;
    got_rv  = imem_rvalid;
    @(posedge clk);
    @(negedge clk);
    if (got_rv) pend = 1'b0;
    if (granted) begin
      pend  = 1'b1;
      paddr = gaddr;
      pwait = lat - 1;
    end else if (pend && pwait > 0) begin
      pwait--;
    end
    imem_rvalid = pend && (pwait == 0) && !withhold;
    imem_rdata  = data_of(paddr);
  endtask

  task automatic fetch_expect(input logic [63:0] pc, input bit stall_rv);
    #1;
    check("fetch_req", 64'(imem_req), 64'd1);
    check("fetch_addr", imem_addr, pc);
    cycle();
    Stall_D = stall_rv;
    cycle();
    Stall_D = 1'b0;
    check("fetch_pc_d", PC_D, pc);
    check("fetch_instr_d", 64'(Instr_D), 64'(data_of(pc)));
    check("fetch_valid_d", 64'(Valid_D), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    // reset state
    #12;
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_valid", 64'(Valid_D), 64'd0);
    check("rst_instr", 64'(Instr_D), 64'(NOP));
    check("rst_pc_d", PC_D, 64'd0);
    check("rst_err", 64'(fetch_err), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // straight-line fetch
    fetch_expect(64'h1000, 1'b0);
    fetch_expect(64'h1004, 1'b0);
    fetch_expect(64'h1008, 1'b0);

    // decode stall: 100C lands in the hold buffer, no further requests
    Stall_D = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i == 0) check("stall_addr", imem_addr, 64'h100C);
      if (i >= 2) check("stall_no_req", 64'(imem_req), 64'd0);
      cycle();
      check("stall_pc_d", PC_D, 64'h1008);
      check("stall_valid", 64'(Valid_D), 64'd1);
    end
    Stall_D = 1'b0;
    #1;
    check("hold_no_req", 64'(imem_req), 64'd0);
    cycle();
    check("hold_pc_d", PC_D, 64'h100C);
    check("hold_instr", 64'(Instr_D), 64'(data_of(64'h100C)));
    check("hold_valid", 64'(Valid_D), 64'd1);
    fetch_expect(64'h1010, 1'b0);

    // redirect while waiting: stale response dropped
    lat = 3;
    #1;
    check("rdw_addr", imem_addr, 64'h1014);
    cycle();
    PCSrc_E = 1'b1;
    PCTarget_E = 64'h2002;
    #1;
    check("rdw_req_forced", 64'(imem_req), 64'd0);
    cycle();
    PCSrc_E = 1'b0;
    check("rdw_bubble", 64'(Valid_D), 64'd0);
    cycle();
    check("rdw_wait_valid", 64'(Valid_D), 64'd0);
    cycle();
    check("rdw_dropped", 64'(Valid_D), 64'd0);
    lat = 1;
    fetch_expect(64'h2000, 1'b0);

    // redirect coincident with rvalid: discarded, no drop flag
    #1;
    check("rdv_addr", imem_addr, 64'h2004);
    cycle();
    PCSrc_E = 1'b1;
    PCTarget_E = 64'h3000;
    cycle();
    PCSrc_E = 1'b0;
    check("rdv_discard", 64'(Valid_D), 64'd0);
    fetch_expect(64'h3000, 1'b0);

    // redirect in S_REQ and PC wrap; stall with empty IF/ID still accepts
    PCSrc_E = 1'b1;
    PCTarget_E = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    check("rdq_req_forced", 64'(imem_req), 64'd0);
    cycle();
    PCSrc_E = 1'b0;
    fetch_expect(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    fetch_expect(64'h0, 1'b1);

    // timeout
    withhold = 1'b1;
    #1;
    check("to_addr", imem_addr, 64'h4);
    cycle();
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check("to_err", 64'(fetch_err), 64'(k == 8));
    end
    withhold = 1'b0;
    cycle();
    cycle();
    check("to_late_pc_d", PC_D, 64'h4);
    check("to_late_valid", 64'(Valid_D), 64'd1);
    check("to_sticky", 64'(fetch_err), 64'd1);

    // asynchronous reset mid-wait with a valid instruction held in decode
    Stall_D = 1'b1;
    lat = 3;
    #1;
    check("ar_addr", imem_addr, 64'h8);
    cycle();
    check("ar_held_valid", 64'(Valid_D), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_req", 64'(imem_req), 64'd0);
    check("ar_valid", 64'(Valid_D), 64'd0);
    check("ar_pc_d", PC_D, 64'd0);
    check("ar_instr", 64'(Instr_D), 64'(NOP));
    check("ar_err", 64'(fetch_err), 64'd0);
    check("ar_addr_rst", imem_addr, RST_PC);
    @(negedge clk);
    rst = 1'b1;
    Stall_D = 1'b0;
    pend = 1'b0;
    imem_rvalid = 1'b0;
    lat = 1;
    fetch_expect(RST_PC, 1'b0);
    fetch_expect(RST_PC + 64'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
